serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 119 +++++++++++
 tb/tb_serial_subtractor.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one difference bit per cycle, LSB first.
// A WIDTH-bit subtraction takes WIDTH RUN cycles followed by a one-cycle DONE pulse.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bo
);

    // One extra bit so the counter can represent WIDTH itself (32 needs 6 bits).
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_next;
    logic             br;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       step;

    // Full-subtractor cell: returns {borrow_out, diff}.
    function automatic logic [1:0] sub_bit(input logic ai, input logic bi, input logic bin);
        logic diff;
        logic bout;
        diff = ai ^ bi ^ bin;
        bout = (~ai & bi) | (~(ai ^ bi) & bin);
        return {bout, diff};
    endfunction

    assign step = sub_bit(a_sr[0], b_sr[0], br);

    // New difference bit enters at the MSB; after WIDTH shifts bit 0 sits at position 0.
    always_comb begin
        r_next            = r_sr >> 1;
        r_next[WIDTH-1]   = step[0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            d     <= '0;
            bo    <= 1'b0;
            a_sr  <= '0;
            b_sr  <= '0;
            r_sr  <= '0;
            br    <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        r_sr  <= '0;
                        br    <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end

                RUN: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    br   <= step[1];
                    r_sr <= r_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        d     <= r_next;
                        bo    <= step[1];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end

                DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        r_sr  <= '0;
                        br    <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH = 8, 1 and 32 sharing one clock and reset.
// Drivers queue the expected {bo,d} and done cycle; per-instance monitors check every DONE pulse.
module tb_serial_subtractor;

    typedef struct packed {
        logic [32:0] val;
        logic [31:0] cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    logic mon_en;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int W = (g == 0) ? 8 : (g == 1) ? 1 : 32;

        logic         start;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         busy;
        logic         done;
        logic [W-1:0] d;
        logic         bo;
        exp_t         q[$];

        serial_subtractor #(.WIDTH(W)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .start (start),
            .a     (a),
            .b     (b),
            .busy  (busy),
            .done  (done),
            .d     (d),
            .bo    (bo)
        );

        // n > 1 holds start for n back-to-back acceptances; chk=0 issues without expecting a result.
        task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                             input logic [W-1:0] ed, input logic ebo, input int n,
                             input bit sync, input bit chk, input bit wt);
            exp_t e;
            if (sync) begin
                @(posedge clk);
                #1;
            end
            start = 1'b1;
            a     = ta;
            b     = tb_;
            for (int i = 0; i < n; i++) begin
                e.val = 33'({ebo, ed});
                e.cyc = 32'(cyc + 1 + W + i * (W + 1));
                if (chk) q.push_back(e);
            end
            repeat ((n - 1) * (W + 1) + 1) @(posedge clk);
            #1;
            start = 1'b0;
            a     = W'($urandom);
            b     = W'($urandom);
            if (wt) repeat (W) @(posedge clk);
        endtask

        task automatic rand_run(input int n);
            logic [W-1:0] ta;
            logic [W-1:0] tb_;
            for (int i = 0; i < n; i++) begin
                ta  = W'($urandom);
                tb_ = W'($urandom);
                issue(ta, tb_, W'(ta - tb_), ta < tb_,
                      ($urandom_range(0, 9) == 0) ? 2 : 1, 1'b1, 1'b1, 1'b1);
            end
        endtask

        initial begin
            start = 1'b0;
            a     = '0;
            b     = '0;
        end

        initial begin : monitor
            logic [W:0] hold;
            bit         rst_seen;
            int         run;
            exp_t       e;
            hold     = '0;
            rst_seen = 1'b0;
            run      = 0;
            forever begin
                @(negedge clk);
                if (mon_en) begin
                    if (rst_seen) hold = '0;
                    rst_seen = !rst_n;
                    if (!rst_n) run = 0;
                    else if (busy) run++;
                    else if (!done) run = 0;

                    if (done) begin
                        total++;
                        if (run != W) begin
                            bad++;
                            $display("FAIL busy_len w=%0d cyc=%0d: got %0d want %0d", W, cyc, run, W);
                        end
                        run = 0;
                        total++;
                        if (q.size() == 0) begin
                            bad++;
                            $display("FAIL extra_done w=%0d cyc=%0d: got done=1 want no done", W, cyc);
                        end else begin
                            e = q.pop_front();
                            if ({bo, d} !== e.val[W:0] || 32'(cyc) != e.cyc) begin
                                bad++;
                                $display("FAIL result w=%0d: got {bo,d}=%h at cyc %0d want %h at cyc %0d",
                                         W, {bo, d}, cyc, e.val[W:0], e.cyc);
                            end
                        end
                        hold = {bo, d};
                    end else begin
                        total++;
                        if ({bo, d} !== hold) begin
                            bad++;
                            $display("FAIL hold w=%0d cyc=%0d: got %h want %h", W, cyc, {bo, d}, hold);
                        end
                    end

                    if (q.size() != 0 && 32'(cyc) > q[0].cyc) begin
                        total++;
                        bad++;
                        $display("FAIL missing_done w=%0d cyc=%0d: got no done want done at cyc %0d",
                                 W, cyc, q[0].cyc);
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [32:0] got, input logic [32:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    initial begin
        mon_en = 1'b0;
        rst_n  = 1'b0;
        // start asserted during reset must be ignored
        u[0].start = 1'b1;
        u[0].a     = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 33'(u[0].busy), 33'h0);
        check("reset_done", 33'(u[0].done), 33'h0);
        check("reset_d",    33'(u[0].d),    33'h0);
        check("reset_bo",   33'(u[0].bo),   33'h0);
        check("reset_d32",  33'(u[2].d),    33'h0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // First start accepted on the first edge with rst_n high
        u[0].issue(8'h05, 8'h03, 8'h02, 1'b0, 1, 1'b0, 1'b1, 1'b1);
        u[0].issue(8'h03, 8'h05, 8'hFE, 1'b1, 1, 1'b1, 1'b1, 1'b1);
        u[0].issue(8'h00, 8'hFF, 8'h01, 1'b1, 1, 1'b1, 1'b1, 1'b1);
        u[0].issue(8'h00, 8'h00, 8'h00, 1'b0, 1, 1'b1, 1'b1, 1'b1);
        u[0].issue(8'hFF, 8'hFF, 8'h00, 1'b0, 1, 1'b1, 1'b1, 1'b1);
        u[0].issue(8'h00, 8'h01, 8'hFF, 1'b1, 1, 1'b1, 1'b1, 1'b1);

        // start pulsed 3 cycles into RUN is ignored
        u[0].issue(8'h5A, 8'h3C, 8'h1E, 1'b0, 1, 1'b1, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        u[0].start = 1'b1;
        u[0].a     = 8'hFF;
        u[0].b     = 8'h00;
        @(posedge clk);
        #1;
        u[0].start = 1'b0;
        repeat (8) @(posedge clk);

        // start held high: three back-to-back results
        u[0].issue(8'h80, 8'h01, 8'h7F, 1'b0, 3, 1'b1, 1'b1, 1'b1);

        // Reset at RUN cycle 4 aborts the operation; start in that edge is ignored
        u[0].issue(8'h03, 8'h05, 8'hFE, 1'b1, 1, 1'b1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n      = 1'b0;
        u[0].start = 1'b1;
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        u[0].start = 1'b0;
        check("abort_busy", 33'(u[0].busy), 33'h0);
        check("abort_done", 33'(u[0].done), 33'h0);
        check("abort_d",    33'(u[0].d),    33'h0);
        check("abort_bo",   33'(u[0].bo),   33'h0);
        u[0].issue(8'hC8, 8'h64, 8'h64, 1'b0, 1, 1'b1, 1'b1, 1'b1);

        // WIDTH=1 and WIDTH=32 corners
        u[1].issue(1'b0, 1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b1);
        u[1].issue(1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b1);
        u[1].issue(1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b1);
        u[2].issue(32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1, 1'b1, 1'b1, 1'b1);
        u[2].issue(32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1, 1'b1, 1'b1, 1'b1);

        fork
            u[0].rand_run(1000);
            u[1].rand_run(1000);
            u[2].rand_run(1000);
        join

        repeat (50) @(posedge clk);
        #1;
        check("drain_w8",  33'(u[0].q.size()), 33'h0);
        check("drain_w1",  33'(u[1].q.size()), 33'h0);
        check("drain_w32", 33'(u[2].q.size()), 33'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
